mmio_out_port: RTL and testbench

Memory-mapped output port between the processor data port and data memory. It intercepts processor stores to two reserved addresses and forwards everything else to RAM unchanged. Stores to the data address are queued in a small FIFO and drained to an external consumer over a valid/ready handshake. Loads from the status address return FIFO occupancy and error flags, so programs can poll before writing.

---
 rtl/mmio_pkg.sv | 18 +
 rtl/mmio_out_port_sync_fifo.sv | 61 ++++++
 rtl/mmio_out_port.sv | 88 ++++++++
 tb/tb_mmio_out_port.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped output port: reserved addresses,
// status word bit positions and the flag-clear bit.
package mmio_pkg;

    // Default reserved addresses at the top of a 16-bit data space.
    localparam logic [15:0] DATA_ADDR_DEF = 16'hFFFE;
    localparam logic [15:0] STAT_ADDR_DEF = 16'hFFFF;

    // Status word bit positions; count occupies [ST_CNT_LSB +: log2(DEPTH)+1].
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    // Store-data bit to STAT_ADDR that clears the sticky overflow flag.
    localparam int CLR_OVF    = 2;

endpackage

// File: rtl/mmio_out_port_sync_fifo.sv
// Small synchronous FIFO with registered storage. A push into a full FIFO
// is accepted only when a pop frees the head slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pop needs data; push into full only succeeds alongside a real pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage write at the tail; cleared on reset so dout is never X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_out_port.sv
// Memory-mapped output port: decodes two reserved addresses out of the
// processor data port, queues stores to DATA_ADDR in a FIFO drained over
// valid/ready, and answers loads from STAT_ADDR with occupancy and flags.
module mmio_out_port
    import mmio_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] DATA_ADDR = WIDTH'(DATA_ADDR_DEF),
    parameter logic [WIDTH-1:0] STAT_ADDR = WIDTH'(STAT_ADDR_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic             cpu_we,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic             ram_we,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          hit_d;
    logic          hit_s;
    logic          push_req;
    logic          pop_req;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ovf;
    logic          ovf_set;
    logic          ovf_clr;
    logic [WIDTH-1:0] status;

    assign hit_d    = (cpu_addr == DATA_ADDR);
    assign hit_s    = (cpu_addr == STAT_ADDR);
    assign ram_we   = cpu_we & ~hit_d & ~hit_s;
    assign push_req = cpu_we & hit_d;
    assign pop_req  = out_valid & out_ready;
    assign out_valid = ~fifo_empty;

    // A push is dropped only when full and nothing leaves on the same edge.
    assign ovf_set  = push_req & fifo_full & ~pop_req;
    assign ovf_clr  = cpu_we & hit_s & cpu_wdata[CLR_OVF];

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (cpu_wdata),
        .pop   (pop_req),
        .dout  (out_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky overflow flag; an explicit clear takes priority over a new set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         ovf <= 1'b0;
        else if (ovf_clr) ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
    end

    // Status word assembled from current FIFO state and flags.
    always_comb begin
        status                       = '0;
        status[ST_EMPTY]             = fifo_empty;
        status[ST_FULL]              = fifo_full;
        status[ST_OVF]               = ovf;
        status[ST_CNT_LSB +: CW]     = fifo_count;
    end

    // Load data mux: status, zeros for the data port, else RAM.
    always_comb begin
        cpu_rdata = ram_rdata;
        if (hit_s)      cpu_rdata = status;
        else if (hit_d) cpu_rdata = '0;
    end

endmodule

// File: tb/tb_mmio_out_port.sv
// Directed plus randomized bench for mmio_out_port against a queue-based
// reference model of the port's externally visible behaviour.
module tb_mmio_out_port;

    localparam int          DEPTH = 4;
    localparam logic [15:0] DA    = 16'hFFFE;
    localparam logic [15:0] SA    = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr  = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_we    = 1'b0;
    logic [15:0] cpu_rdata;
    logic [15:0] ram_rdata = '0;
    logic        ram_we;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] q[$];
    bit          m_ovf = 1'b0;

    always #5 clk = ~clk;

    mmio_out_port #(.WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .ram_rdata (ram_rdata),
        .ram_we    (ram_we),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        int n = q.size();
        return 16'((n << 4) | (int'(m_ovf) << 2) | ((n == DEPTH) ? 2 : 0) | ((n == 0) ? 1 : 0));
    endfunction

    // One cycle: drive at negedge, check outputs, model the rising edge.
    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic we,
                       input logic rdy, input logic [15:0] rr);
        logic [15:0] exp_rd;
        bit pop, push, was_full;
        cpu_addr = a; cpu_wdata = d; cpu_we = we; out_ready = rdy; ram_rdata = rr;
        #1;
        exp_rd = (a == SA) ? m_status() : (a == DA) ? 16'h0 : rr;
        chk("cpu_rdata", cpu_rdata, exp_rd);
        chk("ram_we", {15'b0, ram_we}, {15'b0, we && a != DA && a != SA});
        chk("out_valid", {15'b0, out_valid}, {15'b0, q.size() != 0});
        if (q.size() != 0) chk("out_data", out_data, q[0]);
        @(posedge clk);
        pop      = rdy && q.size() > 0;
        push     = we && a == DA;
        was_full = q.size() == DEPTH;
        if (pop) void'(q.pop_front());
        if (push) begin
            if (!was_full || pop) q.push_back(d);
            else m_ovf = 1'b1;
        end
        if (we && a == SA && d[2]) m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_stat(input string tag, input logic [15:0] exp);
        cpu_addr = SA; cpu_we = 1'b0; out_ready = 1'b0;
        #1;
        chk(tag, cpu_rdata, exp);
    endtask

    initial begin
        // Reset state
        cpu_addr = SA;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stat", cpu_rdata, 16'h0001);
        chk("rst_valid", {15'b0, out_valid}, 16'h0);
        chk("rst_data", out_data, 16'h0);
        chk("rst_ramwe", {15'b0, ram_we}, 16'h0);
        @(negedge clk);
        rst = 1'b1;

        // Three stores, nothing drained
        for (int i = 1; i <= 3; i++) cyc(DA, 16'(i), 1'b1, 1'b0, 16'h1111);
        rd_stat("three_stat", 16'h0030);
        chk("three_head", out_data, 16'h0001);

        // Fill then overflow
        cyc(DA, 16'h0004, 1'b1, 1'b0, 16'h0);
        cyc(DA, 16'h00AA, 1'b1, 1'b0, 16'h0);
        rd_stat("ovf_stat", 16'h0046);
        for (int i = 1; i <= 4; i++) begin
            #1; chk("drain_word", out_data, 16'(i));
            cyc(16'h0020, 16'h0, 1'b0, 1'b1, 16'h0);
        end
        rd_stat("drain_empty", 16'h0005);

        // Clear overflow, then a plain RAM store and load
        cyc(SA, 16'h0004, 1'b1, 1'b0, 16'h0);
        rd_stat("clr_stat", 16'h0001);
        cyc(16'h0010, 16'h1234, 1'b1, 1'b0, 16'hBEEF);
        cyc(16'h0010, 16'h0000, 1'b0, 1'b0, 16'h5A5A);

        // Full with simultaneous pop: accepted, no overflow, appended last
        for (int i = 1; i <= 4; i++) cyc(DA, 16'(16'h10 + i), 1'b1, 1'b0, 16'h0);
        cyc(DA, 16'h0055, 1'b1, 1'b1, 16'h0);
        rd_stat("fullpop_stat", 16'h0042);
        for (int i = 0; i < 4; i++) cyc(16'h0030, 16'h0, 1'b0, 1'b1, 16'h0);
        chk("fullpop_last_gone", {15'b0, out_valid}, 16'h0);

        // Asynchronous reset mid-operation with 3 words queued
        for (int i = 0; i < 3; i++) cyc(DA, 16'(16'h70 + i), 1'b1, 1'b0, 16'h0);
        cpu_addr = SA; cpu_we = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", {15'b0, out_valid}, 16'h0);
        chk("arst_stat", cpu_rdata, 16'h0001);
        chk("arst_data", out_data, 16'h0);
        q.delete(); m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        // First edge after reset release may push
        cyc(DA, 16'h0077, 1'b1, 1'b0, 16'h0);
        rd_stat("post_rst_push", 16'h0010);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a, d;
            int sel = $urandom_range(0, 9);
            d = 16'($urandom);
            if (sel < 5)      a = DA;
            else if (sel < 7) a = SA;
            else              a = 16'($urandom_range(0, 16'hFFFD));
            cyc(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
